// File: rtl/dp_mem_arbiter.sv
// dp_mem_arbiter: round-robin arbiter sharing one single-port MEM between ports A and B (optional range check: DP_MEM_ARB_ADDR_CHECK_EN).
// Latency: request sampled in IDLE on cycle T, mem_valid on T+1, rd_data/ready on T+3; one access per 4 cycles.
// Backpressure: requesters hold valid and fields until their one-cycle ready pulse; the losing port simply waits.
module dp_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 49152
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_a,
    input  logic                  op_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  ready_a,
    output logic                  err_a,
    input  logic                  valid_b,
    input  logic                  op_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  ready_b,
    output logic                  err_b,
    output logic                  mem_valid,
    output logic                  mem_op,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    if (MEM_DEPTH < 1 || longint'(MEM_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("dp_mem_arbiter: MEM_DEPTH does not fit in ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic                  last_grant_b;  // doubles as "current owner" once granted
    logic                  win_b;
    logic                  win_op;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_err;
    logic                  err_q;

    always_comb begin
        win_b    = (valid_a && valid_b) ? ~last_grant_b : valid_b;
        win_op   = win_b ? op_b : op_a;
        win_addr = win_b ? addr_b : addr_a;
        win_data = win_b ? wr_data_b : wr_data_a;
    end

`ifdef DP_MEM_ARB_ADDR_CHECK_EN
    assign win_err = (32'(win_addr) >= 32'(MEM_DEPTH));
`else
    assign win_err = 1'b0;
    assign err_q   = 1'b0;
    assign err_a   = 1'b0;
    assign err_b   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            mem_valid    <= 1'b0;
            mem_op       <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            rd_data_a    <= '0;
            rd_data_b    <= '0;
            ready_a      <= 1'b0;
            ready_b      <= 1'b0;
`ifdef DP_MEM_ARB_ADDR_CHECK_EN
            err_q        <= 1'b0;
            err_a        <= 1'b0;
            err_b        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_a || valid_b) begin
                        last_grant_b <= win_b;
                        mem_op       <= win_op;
                        mem_addr     <= win_addr;
                        mem_wr_data  <= win_data;
                        // out-of-range requests still walk the FSM, just never strobe MEM
                        mem_valid    <= ~win_err;
`ifdef DP_MEM_ARB_ADDR_CHECK_EN
                        err_q        <= win_err;
`endif
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_valid <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    if (!mem_op && !err_q) begin
                        if (last_grant_b) rd_data_b <= mem_rd_data;
                        else              rd_data_a <= mem_rd_data;
                    end
                    ready_a <= ~last_grant_b;
                    ready_b <= last_grant_b;
`ifdef DP_MEM_ARB_ADDR_CHECK_EN
                    err_a   <= err_q & ~last_grant_b;
                    err_b   <= err_q & last_grant_b;
`endif
                    state   <= DONE;
                end
                DONE: begin
                    ready_a <= 1'b0;
                    ready_b <= 1'b0;
`ifdef DP_MEM_ARB_ADDR_CHECK_EN
                    err_a   <= 1'b0;
                    err_b   <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dp_mem_arbiter.md
# dp_mem_arbiter

Two-requester round-robin arbiter that shares one single-port `MEM` instance between ports A and B, giving each requester a valid/ready request interface. It sits between the two client ports of the dual-port memory subsystem and the single-port storage array, and it serializes all accesses. Each access takes a fixed 3 cycles from grant to completion. Fairness under contention is guaranteed by strict alternation.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: data bus width.
- `ADDR_WIDTH`, default 16: address width.
- `MEM_DEPTH`, default 49152: number of valid words (addresses 0..MEM_DEPTH-1).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `valid_a` / `valid_b`  in  1  request pending on that port.
- `op_a` / `op_b`  in  1  operation select: 1 = write, 0 = read.
- `wr_data_a` / `wr_data_b`  in  DATA_WIDTH  write data.
- `addr_a` / `addr_b`  in  ADDR_WIDTH  word address.
- `rd_data_a` / `rd_data_b`  out  DATA_WIDTH  registered read data for that port.
- `ready_a` / `ready_b`  out  1  one-cycle completion pulse.
- `err_a` / `err_b`  out  1  error flag, qualified by ready.
- `mem_valid`  out  1  access strobe to `MEM`.
- `mem_op`  out  1  operation to `MEM` (1 = write).
- `mem_wr_data`  out  DATA_WIDTH  write data to `MEM`.
- `mem_addr`  out  ADDR_WIDTH  address to `MEM`.
- `mem_rd_data`  in  DATA_WIDTH  `MEM` read data, valid on the cycle after `mem_valid`.

## Operation
- State machine states: IDLE, ACCESS, CAPTURE, DONE.
- **IDLE:** if any `valid_x` is high, select a winner and register its op, addr and wr_data into the `mem_*` outputs, then go to ACCESS. If no request is valid, stay in IDLE.
- **Winner selection:** with one port valid, that port wins. With both valid, the port not granted last wins. The `last_grant` register resets to B, so A wins the first tie.
- **ACCESS:** `mem_valid` is high for exactly this cycle. Next state is CAPTURE.
- **CAPTURE:** for a read, `rd_data_x` is loaded from `mem_rd_data` at the end of this cycle. For a write, `rd_data_x` is unchanged. Next state is DONE.
- **DONE:** `ready_x` of the granted port is high for this cycle only. Next state is IDLE.
- The request is captured at grant. Changes to, or deassertion of, `valid_x` or its fields after grant do not affect the access in flight.
- Requesters hold `valid_x` and its fields stable until `ready_x`. They deassert `valid_x`, or present a new request, in the cycle after `ready_x`. Because IDLE follows DONE, a still-held request is not re-granted twice.
- `rd_data_x` holds its value until the next completed read on the same port.
- `ready_a` and `ready_b` are never high in the same cycle.
- `mem_valid` is never high outside ACCESS.

## Timing
- **Reset:** while `rstn` is low, every output is 0, state is IDLE and `last_grant` is B. Assertion takes effect asynchronously.
- **Reset mid-operation:** the access in flight is aborted with no `ready` pulse, and `mem_valid` drops immediately. A write already strobed to `MEM` may have landed.
- **Latency:** `valid_x` is sampled in IDLE on cycle T. `mem_valid` is high on T+1. `rd_data_x` is updated and `ready_x` is high on T+3.
- **Throughput:** one access per 4 cycles. With both ports continuously valid, grants alternate A, B, A, B; each port completes every 8 cycles.
- **Simultaneous arrival on an idle arbiter:** resolved in the same IDLE cycle by the `last_grant` rule.

## Configuration
- `DP_MEM_ARB_ADDR_CHECK_EN` defined:
  - In IDLE, a granted request with addr >= MEM_DEPTH does not raise `mem_valid`.
  - The arbiter still walks ACCESS, CAPTURE and DONE with the same 3-cycle latency.
  - In DONE it asserts `ready_x` and `err_x` together. `rd_data_x` is unchanged.
  - `last_grant` updates normally.
- `DP_MEM_ARB_ADDR_CHECK_EN` undefined:
  - No range check; all addresses are passed to `MEM`.
  - `err_a` and `err_b` are tied to 0.

## Test plan
- **Reset values:** reset, then release with no requests -> all outputs 0 and `mem_valid` never rises over 20 cycles.
- **Single write then read on A:** A writes addr 0x0010, data 0xDEADBEEF, then reads 0x0010 -> `ready_a` at T+3 for each access; `rd_data_a` = 0xDEADBEEF after the read; `rd_data_b` stays 0.
- **Simultaneous requests:** A and B both valid in the same cycle after reset, A writes 0x1 at addr 5, B reads addr 5 -> A is granted first; B's `ready_b` comes 4 cycles after `ready_a` with `rd_data_b` = 0x1.
- **Continuous contention:** A and B held valid for 32 cycles -> grant order A, B, A, B; no two consecutive grants to the same port; `ready_a` and `ready_b` never coincide.
- **Reset mid-access:** `rstn` pulled low during CAPTURE of a read on B -> no `ready_b`; after release, a new read on A completes normally with A granted first.
- **Address range check (with `DP_MEM_ARB_ADDR_CHECK_EN`):** read at addr 49152 -> no `mem_valid`; `ready_a` = `err_a` = 1 at T+3; `rd_data_a` unchanged. Addr 49151 -> normal access with `err_a` = 0.
